// File: rtl/data_pack.sv
// Serial-to-parallel lane packer: collects WIDTH-bit beats into a LANES*WIDTH word.
// The collect register fills while the output register holds the previous word.
module data_pack #(
    parameter int WIDTH = 8,
    parameter int LANES = 8,
    localparam int CW   = $clog2(LANES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CW-1:0]          out_count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          fill_lvl
);

    logic [LANES*WIDTH-1:0] collect_reg;
    logic [LANES*WIDTH-1:0] merged;
    logic [LANES*WIDTH-1:0] out_data_reg;
    logic [CW-1:0]          out_count_reg;
    logic                   out_valid_reg;
    logic [CW-1:0]          fill_lvl_reg;

    logic pending;
    logic closing;
    logic accept;
    logic close_word;
    logic taken;

    assign pending    = out_valid_reg & ~out_ready;
    assign closing    = (fill_lvl_reg == CW'(LANES - 1)) | in_last;
    // Only a word-closing beat needs room in the output register.
    assign in_ready   = ~pending | ~closing;
    assign accept     = in_valid & in_ready;
    assign close_word = accept & closing;
    assign taken      = out_valid_reg & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign merged[gi*WIDTH +: WIDTH] = (fill_lvl_reg == CW'(gi)) ? in_data
                                                                         : collect_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collect_reg   <= '0;
            fill_lvl_reg  <= '0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (close_word) begin
                out_data_reg  <= merged;
                out_count_reg <= fill_lvl_reg + 1'b1;
                out_valid_reg <= 1'b1;
                collect_reg   <= '0;
                fill_lvl_reg  <= '0;
            end else begin
                if (accept) begin
                    collect_reg  <= merged;
                    fill_lvl_reg <= fill_lvl_reg + 1'b1;
                end
                if (taken) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;
    assign out_valid = out_valid_reg;
    assign fill_lvl  = fill_lvl_reg;

endmodule

// File: tb/tb_data_pack.sv
// Directed self-checking bench for data_pack at default parameters (8 lanes x 8 bits).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_data_pack;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic [3:0]  out_count;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fill_lvl;

    int n_checks;
    int n_fail;

    data_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill_lvl  (fill_lvl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [7:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
    endtask

    task automatic idle_check_word(input string name, input logic [63:0] exp_data,
                                   input logic [3:0] exp_count);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: got %b expected 1", name, out_valid);
        end
        n_checks++;
        if (out_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s_data: got %h expected %h", name, out_data, exp_data);
        end
        n_checks++;
        if (out_count !== exp_count) begin
            n_fail++;
            $display("FAIL %s_count: got %0d expected %0d", name, out_count, exp_count);
        end
        $display("word %s: data=%h count=%0d", name, out_data, out_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_lvl !== 4'd0 ||
            out_data !== 64'd0 || out_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b r=%b fill=%0d data=%h cnt=%0d expected v=0 r=1 fill=0 data=0 cnt=0",
                     out_valid, in_ready, fill_lvl, out_data, out_count);
        end
        $display("reset: out_valid=%b in_ready=%b fill_lvl=%0d", out_valid, in_ready, fill_lvl);
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_beat(8'(i), 1'b0);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL t1_ready: beat %0d got %b expected 1", i, in_ready);
            end
        end
        idle_check_word("t1", 64'h0807060504030201, 4'd8);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_valid_drop: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_w [3];
        int k;
        exp_w[0] = 64'h0706050403020100;
        exp_w[1] = 64'h0F0E0D0C0B0A0908;
        exp_w[2] = 64'h1716151413121110;
        k = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_checks++;
                if (k >= 3 || out_data !== exp_w[k]) begin
                    n_fail++;
                    $display("FAIL t2_word%0d: got %h expected %h", k, out_data, (k < 3) ? exp_w[k] : 64'hx);
                end
                $display("word t2_%0d: data=%h", k, out_data);
                k++;
            end
            if (i < 24) begin
                in_valid = 1'b1; in_data = 8'(i); in_last = 1'b0;
                #1;
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL t2_ready: beat %0d got %b expected 1", i, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (k != 3) begin
            n_fail++;
            $display("FAIL t2_word_count: got %0d expected 3", k);
        end
    endtask

    task automatic test_backpressure();
        int  i;
        logic acc;
        i = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'(8'h30 + i); in_last = 1'b0;
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) i++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (i != 15) begin
            n_fail++;
            $display("FAIL t3_accepted: got %0d expected 15", i);
        end
        n_checks++;
        if (in_ready !== 1'b0 || fill_lvl !== 4'd7) begin
            n_fail++;
            $display("FAIL t3_stall: got ready=%b fill=%0d expected ready=0 fill=7", in_ready, fill_lvl);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h3736353433323130) begin
            n_fail++;
            $display("FAIL t3_hold: got v=%b data=%h expected v=1 data=3736353433323130", out_valid, out_data);
        end
        $display("t3 stalled: accepted=%0d fill_lvl=%0d held=%h", i, fill_lvl, out_data);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_release_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        idle_check_word("t3_w2", 64'h3F3E3D3C3B3A3938, 4'd8);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || fill_lvl !== 4'd0) begin
            n_fail++;
            $display("FAIL t3_drain: got v=%b fill=%0d expected v=0 fill=0", out_valid, fill_lvl);
        end
    endtask

    task automatic test_last();
        out_ready = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b1);
        idle_check_word("t4_partial", 64'h0000000000CCBBAA, 4'd3);
        n_checks++;
        if (fill_lvl !== 4'd0) begin
            n_fail++;
            $display("FAIL t4_fill: got %0d expected 0", fill_lvl);
        end
        send_beat(8'h11, 1'b1);
        idle_check_word("t4_next", 64'h0000000000000011, 4'd1);
        send_beat(8'h5A, 1'b1);
        idle_check_word("t5_single", 64'h000000000000005A, 4'd1);
        for (int i = 0; i < 8; i++) send_beat(8'(8'h81 + i), 1'b0);
        idle_check_word("t5_full", 64'h8887868584838281, 4'd8);
        // in_last on the eighth lane is still a plain full word
        for (int i = 0; i < 8; i++) send_beat(8'(8'h91 + i), i == 7);
        idle_check_word("t5_last_full", 64'h9897969594939291, 4'd8);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(8'(8'hE0 + i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fill_lvl !== 4'd0) begin
            n_fail++;
            $display("FAIL t6_rst_fill: got v=%b fill=%0d expected v=0 fill=0", out_valid, fill_lvl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(8'(8'hF0 + i), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_pending: got %b expected 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fill_lvl !== 4'd0 || out_data !== 64'd0) begin
            n_fail++;
            $display("FAIL t6_rst_hold: got v=%b fill=%0d data=%h expected v=0 fill=0 data=0",
                     out_valid, fill_lvl, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(8'(8'hC1 + i), 1'b0);
            if (i < 7) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL t6_stale: beat %0d got out_valid=%b expected 0", i, out_valid);
                end
            end
        end
        idle_check_word("t6_fresh", 64'hC8C7C6C5C4C3C2C1, 4'd8);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_word();
        test_back_to_back();
        test_backpressure();
        test_last();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
